// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller datapath: sequencer
// state encoding, request-line count and the spurious (IR7) index.
package pic_pkg;

    localparam int IR_COUNT = 8;

    // Index reported to the in-service stage when no valid winner existed
    // at the first acknowledge; it makes that stage emit the IR7 vector.
    localparam logic [2:0] SPURIOUS_INDEX = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ACK1    = 3'd2,
        WAIT_R1 = 3'd3,
        WAIT_F2 = 3'd4,
        ACK2    = 3'd5,
        WAIT_R2 = 3'd6
    } seqState_t;

    // One-hot mask for a request index, used to clear the serviced irr bit.
    function automatic logic [IR_COUNT-1:0] indexToOneHot(input logic [2:0] idx);
        logic [IR_COUNT-1:0] mask;
        mask = {{(IR_COUNT-1){1'b0}}, 1'b1};
        return mask << idx;
    endfunction

endpackage

// File: rtl/pic_priority_arbiter.sv
// Combinational fully-nested priority resolver. Walks the request lines
// circularly starting at the priority-0 index; the first unmasked request
// wins unless an in-service bit is met at or before it.
import pic_pkg::*;

module pic_priority_arbiter (
    input  logic [IR_COUNT-1:0] irr,
    input  logic [IR_COUNT-1:0] imr,
    input  logic [IR_COUNT-1:0] isr,
    input  logic [2:0]          zeroLevelIndex,
    output logic                winValid,
    output logic [2:0]          winIndex
);

    logic [IR_COUNT-1:0] candidates_s;
    logic [2:0]          probe_s;
    logic                scanDone_s;

    // Circular scan from highest to lowest priority; stops at the first
    // in-service bit (blocks everything below) or first candidate.
    always_comb begin
        candidates_s = irr & ~imr;
        winValid     = 1'b0;
        winIndex     = SPURIOUS_INDEX;
        scanDone_s   = 1'b0;
        probe_s      = 3'd0;
        for (int k = 0; k < IR_COUNT; k++) begin
            probe_s = zeroLevelIndex + 3'(k);
            if (!scanDone_s && isr[probe_s]) begin
                scanDone_s = 1'b1;
            end else if (!scanDone_s && candidates_s[probe_s]) begin
                winValid   = 1'b1;
                winIndex   = probe_s;
                scanDone_s = 1'b1;
            end else begin
                scanDone_s = scanDone_s;
            end
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// Upstream control stage of the in-service register: raises INT for the
// winning request and runs the two-pulse INTA handshake, driving the
// commit / vector pulses and the irr clear.
import pic_pkg::*;

module inta_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IR_COUNT-1:0] irr,
    input  logic [IR_COUNT-1:0] imr,
    input  logic [IR_COUNT-1:0] isrRegValue,
    input  logic [2:0]          zeroLevelIndex,
    input  logic                intaN,
    output logic                INT,
    output logic [2:0]          toSet,
    output logic                readPriority,
    output logic                sendVector,
    output logic                secondACK,
    output logic [IR_COUNT-1:0] clearIrr,
    output logic                spurious
);

    logic [SYNC_STAGES-1:0] syncChain_r;
    logic                   intaPrev_r;
    logic                   intaSync_s;
    logic                   intaFall_s;
    logic                   intaRise_s;
    logic                   winValid_s;
    logic [2:0]             winIndex_s;
    seqState_t              state_r;

    pic_priority_arbiter uArbiter (
        .irr            (irr),
        .imr            (imr),
        .isr            (isrRegValue),
        .zeroLevelIndex (zeroLevelIndex),
        .winValid       (winValid_s),
        .winIndex       (winIndex_s)
    );

    assign intaSync_s = syncChain_r[SYNC_STAGES-1];
    assign intaFall_s = (intaSync_s == 1'b0) && (intaPrev_r == 1'b1);
    assign intaRise_s = (intaSync_s == 1'b1) && (intaPrev_r == 1'b0);

    // Synchronise the asynchronous acknowledge pin; preload to inactive-high
    // so leaving reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncChain_r <= {SYNC_STAGES{1'b1}};
            intaPrev_r  <= 1'b1;
        end else begin
            syncChain_r[0] <= intaN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChain_r[i] <= syncChain_r[i-1];
            end
            intaPrev_r <= intaSync_s;
        end
    end

    // Handshake FSM with registered outputs; pulses are raised on entry to
    // ACK1/ACK2 so they are high for exactly the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            INT          <= 1'b0;
            toSet        <= SPURIOUS_INDEX;
            readPriority <= 1'b0;
            sendVector   <= 1'b0;
            secondACK    <= 1'b0;
            clearIrr     <= {IR_COUNT{1'b0}};
            spurious     <= 1'b0;
        end else begin
            readPriority <= 1'b0;
            sendVector   <= 1'b0;
            secondACK    <= 1'b0;
            clearIrr     <= {IR_COUNT{1'b0}};
            case (state_r)
                IDLE: begin
                    if (winValid_s) begin
                        state_r <= REQ;
                        INT     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // Winner is re-evaluated at the first acknowledge; a
                    // withdrawn request becomes a spurious (IR7) cycle.
                    if (intaFall_s) begin
                        state_r <= ACK1;
                        INT     <= 1'b0;
                        if (winValid_s) begin
                            toSet        <= winIndex_s;
                            readPriority <= 1'b1;
                            clearIrr     <= indexToOneHot(winIndex_s);
                            spurious     <= 1'b0;
                        end else begin
                            toSet    <= SPURIOUS_INDEX;
                            spurious <= 1'b1;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                ACK1: begin
                    state_r <= WAIT_R1;
                end
                WAIT_R1: begin
                    if (intaRise_s) begin
                        state_r <= WAIT_F2;
                    end else begin
                        state_r <= WAIT_R1;
                    end
                end
                WAIT_F2: begin
                    // Vector is sent even for spurious cycles.
                    if (intaFall_s) begin
                        state_r    <= ACK2;
                        sendVector <= 1'b1;
                        secondACK  <= 1'b1;
                    end else begin
                        state_r <= WAIT_F2;
                    end
                end
                ACK2: begin
                    state_r <= WAIT_R2;
                end
                WAIT_R2: begin
                    if (intaRise_s) begin
                        state_r  <= IDLE;
                        toSet    <= SPURIOUS_INDEX;
                        spurious <= 1'b0;
                    end else begin
                        state_r <= WAIT_R2;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    INT      <= 1'b0;
                    toSet    <= SPURIOUS_INDEX;
                    spurious <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: reset state, normal INTA cycles,
// rotated priority, nested blocking, spurious cycle, mid-cycle reset, masking.
module tb_inta_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [7:0] isrRegValue;
    logic [2:0] zeroLevelIndex;
    logic       intaN;
    logic       INT;
    logic [2:0] toSet;
    logic       readPriority;
    logic       sendVector;
    logic       secondACK;
    logic [7:0] clearIrr;
    logic       spurious;

    int passCnt  = 0;
    int totalCnt = 0;

    int cntRead   = 0;
    int cntSend   = 0;
    int cntSecond = 0;
    int cntClr    = 0;
    logic [7:0] lastClr = 8'h00;

    int baseRead;
    int baseSend;
    int baseSecond;
    int baseClr;

    inta_sequencer #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .irr            (irr),
        .imr            (imr),
        .isrRegValue    (isrRegValue),
        .zeroLevelIndex (zeroLevelIndex),
        .intaN          (intaN),
        .INT            (INT),
        .toSet          (toSet),
        .readPriority   (readPriority),
        .sendVector     (sendVector),
        .secondACK      (secondACK),
        .clearIrr       (clearIrr),
        .spurious       (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every high cycle of each pulse output; a correct pulse adds one.
    always @(posedge clk) begin
        if (readPriority) cntRead <= cntRead + 1;
        if (sendVector)   cntSend <= cntSend + 1;
        if (secondACK)    cntSecond <= cntSecond + 1;
        if (clearIrr != 8'h00) begin
            cntClr  <= cntClr + 1;
            lastClr <= clearIrr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCnt++;
        assert (observed === expected) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic snapshot();
        tick(0);
        baseRead   = cntRead;
        baseSend   = cntSend;
        baseSecond = cntSecond;
        baseClr    = cntClr;
    endtask

    initial begin
        reset = 1'b1; irr = 8'h00; imr = 8'h00; isrRegValue = 8'h00;
        zeroLevelIndex = 3'd0; intaN = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        // 1: reset values, no INT while irr is empty
        check("rst_toSet", 32'(toSet), 32'd7);
        check("rst_clearIrr", 32'(clearIrr), 32'h00);
        check("rst_pulses", 32'({readPriority, sendVector, secondACK, spurious}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("idle_INT", 32'(INT), 32'd0);
            tick(1);
        end

        // 2: irr=24, base priority 0 -> IR2 wins
        irr = 8'h24;
        snapshot();
        tick(2);
        check("t2_INT", 32'(INT), 32'd1);
        intaN = 1'b0; tick(6);
        irr = 8'h00;
        check("t2_toSet", 32'(toSet), 32'd2);
        check("t2_INT_drop", 32'(INT), 32'd0);
        check("t2_spurious", 32'(spurious), 32'd0);
        check("t2_readCnt", 32'(cntRead - baseRead), 32'd1);
        check("t2_clrCnt", 32'(cntClr - baseClr), 32'd1);
        check("t2_clrVal", 32'(lastClr), 32'h04);
        check("t2_noSendYet", 32'(cntSend - baseSend), 32'd0);
        intaN = 1'b1; tick(6);
        intaN = 1'b0; tick(6);
        check("t2_sendCnt", 32'(cntSend - baseSend), 32'd1);
        check("t2_secondCnt", 32'(cntSecond - baseSecond), 32'd1);
        check("t2_toSetHeld", 32'(toSet), 32'd2);
        intaN = 1'b1; tick(6);
        check("t2_toSetIdle", 32'(toSet), 32'd7);
        check("t2_INT_idle", 32'(INT), 32'd0);

        // 3: rotated priority, base at 5 -> IR5 beats IR2
        zeroLevelIndex = 3'd5; irr = 8'h24;
        snapshot();
        tick(2);
        check("t3_INT", 32'(INT), 32'd1);
        intaN = 1'b0; tick(6);
        irr = 8'h00;
        check("t3_toSet", 32'(toSet), 32'd5);
        check("t3_clrVal", 32'(lastClr), 32'h20);
        intaN = 1'b1; tick(6);
        intaN = 1'b0; tick(6);
        intaN = 1'b1; tick(6);
        check("t3_toSetIdle", 32'(toSet), 32'd7);
        // nested: IR2 in service blocks lower-priority IR4
        zeroLevelIndex = 3'd0; isrRegValue = 8'h04; irr = 8'h10;
        tick(4);
        check("t3_nested_INT", 32'(INT), 32'd0);
        irr = 8'h00; isrRegValue = 8'h00;
        tick(2);

        // 4: request withdrawn before first INTA -> spurious cycle
        irr = 8'h08;
        snapshot();
        tick(2);
        check("t4_INT", 32'(INT), 32'd1);
        irr = 8'h00;
        tick(3);
        check("t4_INT_held", 32'(INT), 32'd1);
        intaN = 1'b0; tick(6);
        check("t4_spurious", 32'(spurious), 32'd1);
        check("t4_toSet", 32'(toSet), 32'd7);
        check("t4_readCnt", 32'(cntRead - baseRead), 32'd0);
        check("t4_clrCnt", 32'(cntClr - baseClr), 32'd0);
        intaN = 1'b1; tick(6);
        intaN = 1'b0; tick(6);
        check("t4_sendCnt", 32'(cntSend - baseSend), 32'd1);
        check("t4_secondCnt", 32'(cntSecond - baseSecond), 32'd1);
        intaN = 1'b1; tick(6);
        check("t4_spuriousIdle", 32'(spurious), 32'd0);

        // 5: reset while waiting for the second fall aborts the cycle
        irr = 8'h01;
        snapshot();
        tick(2);
        check("t5_INT", 32'(INT), 32'd1);
        intaN = 1'b0; tick(6);
        irr = 8'h00;
        check("t5_toSet", 32'(toSet), 32'd0);
        intaN = 1'b1; tick(6);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        check("t5_rst_toSet", 32'(toSet), 32'd7);
        check("t5_rst_INT", 32'(INT), 32'd0);
        intaN = 1'b0; tick(6);
        intaN = 1'b1; tick(6);
        intaN = 1'b0; tick(6);
        intaN = 1'b1; tick(6);
        check("t5_noSend", 32'(cntSend - baseSend), 32'd0);
        check("t5_noRead", 32'(cntRead - baseRead), 32'd1);
        check("t5_INT_after", 32'(INT), 32'd0);

        // 6: masked request stays quiet until the mask is cleared
        imr = 8'h04; irr = 8'h04;
        tick(4);
        check("t6_masked_INT", 32'(INT), 32'd0);
        imr = 8'h00;
        tick(2);
        check("t6_unmasked_INT", 32'(INT), 32'd1);
        intaN = 1'b0; tick(6);
        irr = 8'h00;
        check("t6_toSet", 32'(toSet), 32'd2);
        intaN = 1'b1; tick(6);
        intaN = 1'b0; tick(6);
        intaN = 1'b1; tick(6);
        check("t6_toSetIdle", 32'(toSet), 32'd7);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
